// File: rtl/mac_pkg.sv
// Shared definitions for the a*b*c+d job feeder: operand width default,
// packed tuple width and the issue FSM state encoding.
package mac_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int TUPLE_W   = 4 * DEF_WIDTH;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mac_job_feeder_if.sv
// Handshake bundle around the feeder: the producer valid/ready stream on one
// side and the start/busy operand port to the arithmetic unit on the other.
// The slave modport is the feeder's view; master is the surrounding system.
interface mac_job_feeder_if import mac_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] in_c;
   logic [WIDTH-1:0] in_d;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic             start;
   logic             busy;

   modport master (
      output in_valid, in_a, in_b, in_c, in_d, busy,
      input  in_ready, a, b, c, d, start
   );

   modport slave (
      input  in_valid, in_a, in_b, in_c, in_d, busy,
      output in_ready, a, b, c, d, start
   );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding packed operand tuples. Power-of-two depth,
// so the read/write pointers wrap naturally; an occupancy counter gives
// full/empty without pointer-extension tricks. Push when full and pop when
// empty are ignored.
module sync_fifo import mac_pkg::*; #(
   parameter int WIDTH = TUPLE_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == CNT_MAX);
   assign empty     = (count_r == '0);
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;
   assign head      = mem_r[rd_ptr_r];

   // Storage write; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/mac_job_feeder.sv
// Operand sequencer for the non-pipelined a*b*c+d unit. Tuples are queued in
// a FIFO and issued one at a time over start/busy; the head stays in the FIFO
// until its job finishes or is abandoned after a busy-rise timeout.
module mac_job_feeder import mac_pkg::*; #(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   mac_job_feeder_if.slave   bus,
   output logic              idle,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  done_count
);

   localparam int TW    = 4 * WIDTH;
   localparam int TMR_W = $clog2(TIMEOUT) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_r, state_s;
   logic [TMR_W-1:0] timer_r;
   logic             start_r, start_s;
   logic             load_s, pop_s, err_set_s, done_inc_s;
   logic             push_s, full_s, empty_s;
   logic [TW-1:0]    tuple_s, head_s;
   logic [WIDTH-1:0] a_r, b_r, c_r, d_r;
   logic             timeout_err_r;
   logic [CNT_W-1:0] done_count_r;

   assign tuple_s      = {bus.in_a, bus.in_b, bus.in_c, bus.in_d};
   assign push_s       = bus.in_valid && !full_s;
   assign bus.in_ready = !full_s;
   assign bus.start    = start_r;
   assign bus.a        = a_r;
   assign bus.b        = b_r;
   assign bus.c        = c_r;
   assign bus.d        = d_r;
   assign idle         = (state_r == IDLE) && empty_s;
   assign timeout_err  = timeout_err_r;
   assign done_count   = done_count_r;

   sync_fifo #(.WIDTH(TW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .din   (tuple_s),
      .full  (full_s),
      .empty (empty_s),
      .head  (head_s)
   );

   // Issue FSM: next state, next start level and one-cycle side-effect strobes.
   always_comb begin
      state_s    = state_r;
      start_s    = 1'b0;
      load_s     = 1'b0;
      pop_s      = 1'b0;
      err_set_s  = 1'b0;
      done_inc_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               load_s  = 1'b1;
               start_s = 1'b1;
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            // busy already high on entry counts as the rise
            if (bus.busy) begin
               state_s = WAIT_DONE;
            end else if (timer_r == TMR_LAST) begin
               pop_s     = 1'b1;
               err_set_s = 1'b1;
               state_s   = IDLE;
            end else begin
               start_s = 1'b1;
               state_s = ISSUE;
            end
         end
         WAIT_DONE: begin
            if (!bus.busy) begin
               pop_s      = 1'b1;
               done_inc_s = 1'b1;
               state_s    = IDLE;
            end else begin
               state_s = WAIT_DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and start registers; reset drops start at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         start_r <= 1'b0;
      end else begin
         state_r <= state_s;
         start_r <= start_s;
      end
   end

   // Busy-rise timer: cleared when a job is launched, counts while in ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_r <= '0;
      end else if (load_s) begin
         timer_r <= '0;
      end else if (state_r == ISSUE) begin
         timer_r <= timer_r + TMR_ONE;
      end
   end

   // Operand registers capture the FIFO head when a job is launched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r <= '0;
         b_r <= '0;
         c_r <= '0;
         d_r <= '0;
      end else if (load_s) begin
         {a_r, b_r, c_r, d_r} <= head_s;
      end
   end

   // Sticky timeout flag and wrapping completed-job counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_err_r <= 1'b0;
         done_count_r  <= '0;
      end else begin
         if (err_set_s) begin
            timeout_err_r <= 1'b1;
         end
         if (done_inc_s) begin
            done_count_r <= done_count_r + CNT_ONE;
         end
      end
   end

endmodule
